// File: rtl/attosoc_uart_tx.sv
// rtl/attosoc_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and run-time baud divider
module attosoc_uart_tx #(
  parameter logic [31:0] BASE_ADDR     = 32'h0200_0000,
  parameter int          FIFO_DEPTH    = 8,
  parameter logic [15:0] CLK_DIV_RESET = 16'd104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iomem_valid,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  input  logic [3:0]  iomem_wstrb,
  output logic        iomem_ready,
  output logic [31:0] iomem_rdata,
  output logic        uart_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  state_t state, state_next;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty, fifo_full;

  logic [15:0] div_reg, bit_period, baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        bit_end, pop;

  logic        sel, data_wr, accept, push;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign unused_bits = ^{iomem_addr[1:0], iomem_wdata[31:16], iomem_wstrb[3:2]};

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));

  // A DATA write into a full FIFO waits for the pop that frees a slot.
  assign sel     = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
  assign data_wr = (iomem_addr[3:2] == 2'd0) && iomem_wstrb[0];
  assign accept  = sel && !iomem_ready && (!data_wr || !fifo_full || pop);
  assign push    = accept && data_wr;

  always_comb begin
    rd_val = '0;
    if (iomem_wstrb == 4'b0000) begin
      case (iomem_addr[3:2])
        2'd1:    rd_val = {29'b0, state != S_IDLE, fifo_empty, fifo_full};
        2'd2:    rd_val = {16'b0, div_reg};
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      div_reg     <= CLK_DIV_RESET;
    end else begin
      iomem_ready <= accept;
      iomem_rdata <= accept ? rd_val : '0;
      if (accept && iomem_addr[3:2] == 2'd2) begin
        if (iomem_wstrb[0]) div_reg[7:0]  <= iomem_wdata[7:0];
        if (iomem_wstrb[1]) div_reg[15:8] <= iomem_wdata[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= iomem_wdata[7:0];
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign bit_end = (baud_cnt == bit_period - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    uart_tx    = 1'b1;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        uart_tx = 1'b0;
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        uart_tx = shift_reg[0];
        if (bit_end && bit_idx == 3'd7) state_next = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Divider is sampled only at frame start, so mid-frame DIV writes affect the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt   <= '0;
      bit_period <= 16'd1;
      bit_idx    <= '0;
      shift_reg  <= '0;
    end else if (pop) begin
      shift_reg  <= fifo_mem[rd_ptr];
      bit_period <= (div_reg == 16'd0) ? 16'd1 : div_reg;
      baud_cnt   <= '0;
      bit_idx    <= '0;
    end else if (state != S_IDLE) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (state == S_DATA) begin
          shift_reg <= shift_reg >> 1;
          bit_idx   <= bit_idx + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end
endmodule
